mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single physical-memory port between the instruction cache (requester 0) and the data-cache eviction/write-back controller (requester 1). Both requesters speak the cache-side stb/cyc/write/resp/retry handshake. The arbiter grants one requester at a time and holds the grant for the whole transaction. It routes resp/retry back to the owner and runs a watchdog that aborts transactions memory never answers.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester ids, bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Requester indices as they appear on the registered grant bit
    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the requester that did not win last time takes a tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: valid0/valid1 requests, last_grant history bit -> grant_valid, grant_idx.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant_idx = ~last_grant;
        end else if (valid1) begin
            grant_idx = REQ_DCACHE;
        end else begin
            grant_idx = REQ_ICACHE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the physical memory port between I-cache (req0) and D-cache write-back (req1).
// Latency: grant registered, mem_action_cyc one cycle after request; resp/retry routed combinationally.
// Backpressure: grant held until mem_resp/mem_retry, owner drop of cyc, or watchdog abort.
// Ports: req0_*/req1_* cache-side stb/cyc/write/addr/wdata in, resp/retry out;
//        mem_* forwarded command out, mem_resp/mem_retry in; timeout_err abort pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_stb,
    input  logic              req0_cyc,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_resp,
    output logic              req0_retry,
    input  logic              req1_stb,
    input  logic              req1_cyc,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_resp,
    output logic              req1_retry,
    output logic              mem_action_stb,
    output logic              mem_action_cyc,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic              mem_retry,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    arb_state_t       state;
    logic             grant;
    logic             last_grant;
    logic [CNT_W-1:0] wdog;

    logic pick_valid;
    logic pick_idx;

    rr_arbiter2 u_rr (
        .valid0      (req0_cyc & req0_stb),
        .valid1      (req1_cyc & req1_stb),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // Owner-side view of the granted requester
    logic              own_stb;
    logic              own_cyc;
    logic              own_write;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    assign own_stb   = (grant == REQ_DCACHE) ? req1_stb   : req0_stb;
    assign own_cyc   = (grant == REQ_DCACHE) ? req1_cyc   : req0_cyc;
    assign own_write = (grant == REQ_DCACHE) ? req1_write : req0_write;
    assign own_addr  = (grant == REQ_DCACHE) ? req1_addr  : req0_addr;
    assign own_wdata = (grant == REQ_DCACHE) ? req1_wdata : req0_wdata;

    logic owner_live;
    logic timeout_hit;
    logic fwd;
    logic done_resp;
    logic done_retry;

    // An owner that has already dropped cyc gets neither resp nor an abort retry.
    assign owner_live  = (state == ARB_BUSY) && own_cyc;
    assign timeout_hit = owner_live && (wdog == TMO);
    // The abort cycle blanks the memory side so memory never sees a half-dead command.
    assign fwd         = owner_live && !timeout_hit;

    assign mem_action_cyc = fwd;
    assign mem_action_stb = fwd & own_stb;
    assign mem_write      = fwd & own_write;
    assign mem_addr       = fwd ? own_addr  : '0;
    assign mem_wdata      = fwd ? own_wdata : '0;

    // resp beats retry when memory signals both
    assign done_resp  = fwd & mem_resp;
    assign done_retry = (fwd & mem_retry & ~mem_resp) | timeout_hit;

    assign req0_resp   = done_resp  & (grant == REQ_ICACHE);
    assign req0_retry  = done_retry & (grant == REQ_ICACHE);
    assign req1_resp   = done_resp  & (grant == REQ_DCACHE);
    assign req1_retry  = done_retry & (grant == REQ_DCACHE);
    assign timeout_err = timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= REQ_ICACHE;
            last_grant <= REQ_DCACHE;
            wdog       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state <= ARB_BUSY;
                        grant <= pick_idx;
                        wdog  <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!own_cyc) begin
                        // Owner abandoned the transaction: release silently
                        state <= ARB_IDLE;
                    end else if (timeout_hit || mem_resp || mem_retry) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end else if (wdog != TMO) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int TMO = 8;

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_2040;
    localparam logic [DW-1:0] W0 = {8{32'h0123_4567}};
    localparam logic [DW-1:0] W1 = {8{32'hDEAD_BEEF}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_stb = 0, req0_cyc = 0, req0_write = 0;
    logic [AW-1:0] req0_addr = A0;
    logic [DW-1:0] req0_wdata = W0;
    logic          req0_resp, req0_retry;
    logic          req1_stb = 0, req1_cyc = 0, req1_write = 1'b1;
    logic [AW-1:0] req1_addr = A1;
    logic [DW-1:0] req1_wdata = W1;
    logic          req1_resp, req1_retry;
    logic          mem_action_stb, mem_action_cyc, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp = 0, mem_retry = 0;
    logic          timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO),
        .CNT_W  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_stb      (req0_stb),
        .req0_cyc      (req0_cyc),
        .req0_write    (req0_write),
        .req0_addr     (req0_addr),
        .req0_wdata    (req0_wdata),
        .req0_resp     (req0_resp),
        .req0_retry    (req0_retry),
        .req1_stb      (req1_stb),
        .req1_cyc      (req1_cyc),
        .req1_write    (req1_write),
        .req1_addr     (req1_addr),
        .req1_wdata    (req1_wdata),
        .req1_resp     (req1_resp),
        .req1_retry    (req1_retry),
        .mem_action_stb(mem_action_stb),
        .mem_action_cyc(mem_action_cyc),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_resp      (mem_resp),
        .mem_retry     (mem_retry),
        .timeout_err   (timeout_err)
    );

    // One row = one clock cycle. src: 0 = memory side idle, 1 = req0 forwarded, 2 = req1 forwarded.
    // rr = {req0_resp, req0_retry, req1_resp, req1_retry}
    typedef struct {
        bit       rst_pre;
        bit       v0;
        bit       v1;
        bit       mr;
        bit       mt;
        int       src;
        logic [3:0] rr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst_pre, input bit v0, input bit v1, input bit mr,
                       input bit mt, input int src, input logic [3:0] rr);
        vec_t v;
        v.rst_pre = rst_pre; v.v0 = v0; v.v1 = v1; v.mr = mr; v.mt = mt;
        v.src = src; v.rr = rr;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit v0, input bit v1, input bit mr, input bit mt);
        req0_stb = v0; req0_cyc = v0;
        req1_stb = v1; req1_cyc = v1;
        mem_resp = mr; mem_retry = mt;
    endtask

    // flags = {cyc, stb, write, resp0, retry0, resp1, retry1, timeout_err}
    task automatic check(input string name, input int src, input logic [3:0] rr, input bit te);
        logic [7:0]    exp_f, act_f;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_w;
        exp_f = {(src == 0) ? 3'b000 : ((src == 1) ? 3'b110 : 3'b111), rr, te};
        exp_a = (src == 1) ? A0 : ((src == 2) ? A1 : '0);
        exp_w = (src == 1) ? W0 : ((src == 2) ? W1 : '0);
        act_f = {mem_action_cyc, mem_action_stb, mem_write,
                 req0_resp, req0_retry, req1_resp, req1_retry, timeout_err};
        n_cmp++;
        if (act_f !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags{cyc,stb,wr,r0,rt0,r1,rt1,to}: got %b want %b", name, act_f, exp_f);
        end
        n_cmp++;
        if (mem_addr !== exp_a) begin
            n_fail++;
            $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, exp_a);
        end
        n_cmp++;
        if (mem_wdata !== exp_w) begin
            n_fail++;
            $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, exp_w);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic cycle(input string name, input bit v0, input bit v1, input bit mr,
                         input bit mt, input int src, input logic [3:0] rr, input bit te);
        @(posedge clk);
        #1;
        drive(v0, v1, mr, mt);
        #3;
        check(name, src, rr, te);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset state, with busy-looking inputs applied ----------------
        drive(1, 1, 1, 1);
        #1;
        rst = 1'b1;
        #2;
        check("reset_outputs", 0, 4'b0000, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- table: single request ----------------
        add(1, 1, 0, 0, 0, 0, 4'b0000);   // idle cycle, request seen
        add(0, 1, 0, 0, 0, 1, 4'b0000);   // granted next cycle
        add(0, 1, 0, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 1, 0, 1, 4'b1000);   // 5th busy cycle: resp to req0 only
        add(0, 0, 0, 0, 0, 0, 4'b0000);
        // ---------------- table: contention from reset, 0,1,0,1 ----------------
        add(1, 1, 1, 0, 0, 0, 4'b0000);
        add(0, 1, 1, 0, 0, 1, 4'b0000);
        add(0, 1, 1, 1, 0, 1, 4'b1000);
        add(0, 1, 1, 0, 0, 0, 4'b0000);
        add(0, 1, 1, 0, 0, 2, 4'b0000);
        add(0, 1, 1, 1, 0, 2, 4'b0010);
        add(0, 1, 1, 0, 0, 0, 4'b0000);
        add(0, 1, 1, 0, 0, 1, 4'b0000);
        add(0, 1, 1, 1, 0, 1, 4'b1000);
        add(0, 1, 1, 0, 0, 0, 4'b0000);
        add(0, 1, 1, 0, 0, 2, 4'b0000);
        add(0, 1, 1, 1, 0, 2, 4'b0010);
        // ---------------- table: retry handoff, resp+retry, owner drop ----------------
        add(0, 0, 1, 0, 0, 0, 4'b0000);   // only req1 valid
        add(0, 1, 1, 0, 0, 2, 4'b0000);   // req1 write owns port, req0 waits
        add(0, 1, 1, 0, 1, 2, 4'b0001);   // retry to req1
        add(0, 1, 1, 0, 0, 0, 4'b0000);   // idle, req0 wins the tie
        add(0, 1, 1, 0, 0, 1, 4'b0000);   // req0 data on the port
        add(0, 1, 1, 1, 1, 1, 4'b1000);   // resp and retry together: resp only
        add(0, 0, 1, 0, 0, 0, 4'b0000);
        add(0, 0, 1, 0, 0, 2, 4'b0000);
        add(0, 0, 0, 1, 0, 0, 4'b0000);   // owner dropped cyc: no resp
        add(0, 0, 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].rst_pre) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end else begin
                #1;
            end
            drive(vecs[i].v0, vecs[i].v1, vecs[i].mr, vecs[i].mt);
            #2;
            check($sformatf("vec%0d", i), vecs[i].src, vecs[i].rr, 1'b0);
        end

        // ---------------- watchdog timeout ----------------
        pulse_reset();
        drive(1, 0, 0, 0);
        #2;
        check("to_idle", 0, 4'b0000, 1'b0);
        for (int k = 1; k <= TMO; k++) begin
            cycle($sformatf("to_busy%0d", k), 1, 0, 0, 0, 1, 4'b0000, 1'b0);
        end
        cycle("to_abort", 1, 0, 0, 0, 0, 4'b0100, 1'b1);
        cycle("to_after", 0, 0, 0, 0, 0, 4'b0000, 1'b0);

        // ---------------- asynchronous reset mid-BUSY ----------------
        pulse_reset();
        drive(1, 1, 0, 0);
        #2;
        check("mr_idle0", 0, 4'b0000, 1'b0);
        cycle("mr_g0", 1, 1, 0, 0, 1, 4'b0000, 1'b0);
        cycle("mr_g0_resp", 1, 1, 1, 0, 1, 4'b1000, 1'b0);
        cycle("mr_idle1", 1, 1, 0, 0, 0, 4'b0000, 1'b0);
        cycle("mr_g1", 1, 1, 0, 0, 2, 4'b0000, 1'b0);
        mem_resp = 1'b1;
        rst = 1'b1;
        #1;
        check("mr_reset_now", 0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 1, 0, 0);
        #3;
        check("mr_post_idle", 0, 4'b0000, 1'b0);
        cycle("mr_post_tie_req0", 1, 1, 0, 0, 1, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
